// File: rtl/rational_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rational_div_pkg
//  Description : Shared types, default geometry and sizing helpers for the
//                rational_div complex divider.
//  Revision    : 1.0  initial release
// ============================================================================
package rational_div_pkg;

    localparam int RD_DATA_WIDTH = 16;
    localparam int RD_FRAC_BITS  = 8;

    localparam int PROD_WIDTH = 2 * RD_DATA_WIDTH;
    localparam int DIV_CYCLES = 2 * RD_DATA_WIDTH + RD_FRAC_BITS;
    localparam int Q_MAX      = (1 << (RD_DATA_WIDTH - 1)) - 1;
    localparam int Q_MIN      = -(1 << (RD_DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int f_prod_width(input int dw);
        return 2 * dw;
    endfunction

    function automatic int f_div_cycles(input int dw, input int fb);
        return 2 * dw + fb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rational_div_udiv_serial.sv
`default_nettype none
// ============================================================================
//  Module      : udiv_serial
//  Description : Unsigned restoring divider, one quotient bit per cycle, MSB
//                first; quotient stays valid after done until the next start.
//  Revision    : 1.0  initial release
// ============================================================================
module udiv_serial #(
    parameter int DVD_W = 40,
    parameter int DVS_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVD_W-1:0] quotient_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(DVD_W);

    // The dividend shifts out of the top while quotient bits shift in below.
    logic [DVD_W-1:0] shf_q, shf_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DVS_W:0]   trial;
    logic             ge;

    assign trial = {rem_q, shf_q[DVD_W-1]};
    assign ge    = (trial >= {1'b0, dvs_q});

    always_comb begin
        shf_d  = shf_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        if (start_i) begin
            shf_d  = dividend_i;
            dvs_d  = divisor_i;
            rem_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q) begin
            rem_d = ge ? DVS_W'(trial - {1'b0, dvs_q}) : trial[DVS_W-1:0];
            shf_d = {shf_q[DVD_W-2:0], ge};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DVD_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shf_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            shf_q  <= shf_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = shf_q;
    assign done_o     = done_q;

endmodule
`default_nettype wire

// File: rtl/rational_div.sv
`default_nettype none
// ============================================================================
//  Module      : rational_div
//  Description : Sequential complex divider H = N/D with saturated fixed-point
//                quotient, divide-by-zero and saturation flags.
//  Revision    : 1.0  initial release
// ============================================================================
module rational_div
    import rational_div_pkg::*;
#(
    parameter int DATA_WIDTH = RD_DATA_WIDTH,
    parameter int FRAC_BITS  = RD_FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] num_re,
    input  logic [DATA_WIDTH-1:0] num_im,
    input  logic [DATA_WIDTH-1:0] den_re,
    input  logic [DATA_WIDTH-1:0] den_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] q_re,
    output logic [DATA_WIDTH-1:0] q_im,
    output logic                  div_zero,
    output logic                  sat
);

    localparam int PROD_W = f_prod_width(DATA_WIDTH);
    localparam int DVD_W  = f_div_cycles(DATA_WIDTH, FRAC_BITS);

    localparam logic [DVD_W-1:0] POS_LIM =
        {{(DVD_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DVD_W-1:0] NEG_LIM = POS_LIM + DVD_W'(1);

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] nr_q, nr_d, ni_q, ni_d, dr_q, dr_d, di_q, di_d;
    logic                  neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic                  zero_q, zero_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] q_re_q, q_re_d, q_im_q, q_im_d;
    logic                  div_zero_q, div_zero_d;
    logic                  sat_q, sat_d;

    // One guard bit above the product width keeps the signed sums exact.
    logic signed [PROD_W:0] nr_x, ni_x, dr_x, di_x;
    logic signed [PROD_W:0] p_re, p_im, mag;
    logic [PROD_W-1:0]      abs_re, abs_im;
    logic [DVD_W-1:0]       dvd_re, dvd_im;
    logic [DVD_W-1:0]       quo_re, quo_im;
    logic                   done_re, done_im;
    logic                   start;
    logic [DATA_WIDTH:0]    sr_re, sr_im;

    assign nr_x = {{(PROD_W + 1 - DATA_WIDTH){nr_q[DATA_WIDTH-1]}}, nr_q};
    assign ni_x = {{(PROD_W + 1 - DATA_WIDTH){ni_q[DATA_WIDTH-1]}}, ni_q};
    assign dr_x = {{(PROD_W + 1 - DATA_WIDTH){dr_q[DATA_WIDTH-1]}}, dr_q};
    assign di_x = {{(PROD_W + 1 - DATA_WIDTH){di_q[DATA_WIDTH-1]}}, di_q};

    assign p_re = nr_x * dr_x + ni_x * di_x;
    assign p_im = ni_x * dr_x - nr_x * di_x;
    assign mag  = dr_x * dr_x + di_x * di_x;

    assign abs_re = p_re[PROD_W] ? PROD_W'(-p_re) : p_re[PROD_W-1:0];
    assign abs_im = p_im[PROD_W] ? PROD_W'(-p_im) : p_im[PROD_W-1:0];
    assign dvd_re = {abs_re, {FRAC_BITS{1'b0}}};
    assign dvd_im = {abs_im, {FRAC_BITS{1'b0}}};

    assign start = (state_q == MUL);

    udiv_serial #(
        .DVD_W (DVD_W),
        .DVS_W (PROD_W)
    ) u_div_re (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .dividend_i (dvd_re),
        .divisor_i  (mag[PROD_W-1:0]),
        .quotient_o (quo_re),
        .done_o     (done_re)
    );

    udiv_serial #(
        .DVD_W (DVD_W),
        .DVS_W (PROD_W)
    ) u_div_im (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .dividend_i (dvd_im),
        .divisor_i  (mag[PROD_W-1:0]),
        .quotient_o (quo_im),
        .done_o     (done_im)
    );

    // Returns {clipped, value}: sign-applied quotient clamped to the Q range.
    function automatic logic [DATA_WIDTH:0] f_sat(input logic [DVD_W-1:0] m,
                                                  input logic            neg);
        if (!neg) begin
            if (m > POS_LIM) return {2'b10, {(DATA_WIDTH - 1){1'b1}}};
            return {1'b0, m[DATA_WIDTH-1:0]};
        end
        if (m > NEG_LIM) return {2'b11, {(DATA_WIDTH - 1){1'b0}}};
        return {1'b0, -m[DATA_WIDTH-1:0]};
    endfunction

    assign sr_re = f_sat(quo_re, neg_re_q);
    assign sr_im = f_sat(quo_im, neg_im_q);

    always_comb begin
        state_d     = state_q;
        nr_d        = nr_q;
        ni_d        = ni_q;
        dr_d        = dr_q;
        di_d        = di_q;
        neg_re_d    = neg_re_q;
        neg_im_d    = neg_im_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        q_re_d      = q_re_q;
        q_im_d      = q_im_q;
        div_zero_d  = div_zero_q;
        sat_d       = sat_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    nr_d    = num_re;
                    ni_d    = num_im;
                    dr_d    = den_re;
                    di_d    = den_im;
                    state_d = MUL;
                end
            end
            MUL: begin
                neg_re_d = p_re[PROD_W];
                neg_im_d = p_im[PROD_W];
                zero_d   = (mag == '0);
                state_d  = DIV;
            end
            DIV: begin
                // A zero denominator leaves after a single cycle; the dividers
                // run on harmlessly and are reloaded by the next start.
                if (zero_q) begin
                    q_re_d      = '0;
                    q_im_d      = '0;
                    div_zero_d  = 1'b1;
                    sat_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (done_re && done_im) begin
                    q_re_d      = sr_re[DATA_WIDTH-1:0];
                    q_im_d      = sr_im[DATA_WIDTH-1:0];
                    div_zero_d  = 1'b0;
                    sat_d       = sr_re[DATA_WIDTH] | sr_im[DATA_WIDTH];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nr_q        <= '0;
            ni_q        <= '0;
            dr_q        <= '0;
            di_q        <= '0;
            neg_re_q    <= 1'b0;
            neg_im_q    <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            q_re_q      <= '0;
            q_im_q      <= '0;
            div_zero_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nr_q        <= nr_d;
            ni_q        <= ni_d;
            dr_q        <= dr_d;
            di_q        <= di_d;
            neg_re_q    <= neg_re_d;
            neg_im_q    <= neg_im_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            q_re_q      <= q_re_d;
            q_im_q      <= q_im_d;
            div_zero_q  <= div_zero_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign q_re      = q_re_q;
    assign q_im      = q_im_q;
    assign div_zero  = div_zero_q;
    assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_rational_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rational_div
//  Description : Scoreboard bench for rational_div with hand-computed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rational_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] num_re, num_im, den_re, den_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q_re, q_im;
    logic        div_zero;
    logic        sat;

    always #5 clk = ~clk;

    rational_div #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_re    (num_re),
        .num_im    (num_im),
        .den_re    (den_re),
        .den_im    (den_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_re      (q_re),
        .q_im      (q_im),
        .div_zero  (div_zero),
        .sat       (sat)
    );

    typedef struct {
        string       name;
        logic [15:0] nr, ni, dr, di;
        logic [15:0] re, im;
        logic        dz, st;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    vec_t        sb[$];
    vec_t        cur;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    bit          holding  = 1'b0;
    logic [33:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on the first cycle a result is shown,
    // then checks that a stalled result stays frozen.
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        check("unexpected result", 64'd1, 64'd0);
                    end else begin
                        cur = sb.pop_front();
                        check({cur.name, " q_re"}, 64'(q_re), 64'(cur.re));
                        check({cur.name, " q_im"}, 64'(q_im), 64'(cur.im));
                        check({cur.name, " div_zero"}, 64'(div_zero), 64'(cur.dz));
                        check({cur.name, " sat"}, 64'(sat), 64'(cur.st));
                        check({cur.name, " latency"}, 64'(cyc - acc_cyc), 64'(cur.lat));
                    end
                    held    = {q_re, q_im, div_zero, sat};
                    holding = 1'b1;
                end else begin
                    check("stall outputs stable", 64'({q_re, q_im, div_zero, sat}), 64'(held));
                    check("stall in_ready low", 64'(in_ready), 64'd0);
                end
                if (out_ready) holding = 1'b0;
            end
        end
    end

    task automatic add(input string n, input logic [15:0] nr, ni, dr, di, re, im,
                       input logic dz, st, input int lat);
        vec_t v;
        v.name = n; v.nr = nr; v.ni = ni; v.dr = dr; v.di = di;
        v.re = re; v.im = im; v.dz = dz; v.st = st; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic send(input vec_t v);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check({v.name, " in_ready before send"}, 64'(in_ready), 64'd1);
        num_re   = v.nr;
        num_im   = v.ni;
        den_re   = v.dr;
        den_im   = v.di;
        in_valid = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) begin
            check("drain timeout", 64'd1, 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   t;
        int   seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        num_re    = '0;
        num_im    = '0;
        den_re    = '0;
        den_im    = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset q", 64'({q_re, q_im}), 64'd0);
        check("reset flags", 64'({div_zero, sat}), 64'd0);

        add("2/1",       16'h0200, 16'h0000, 16'h0100, 16'h0000, 16'h0200, 16'h0000, 1'b0, 1'b0, 42);
        add("i/i",       16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 42);
        add("1/(1+i)",   16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0080, 16'hFF80, 1'b0, 1'b0, 42);
        add("div0",      16'h1234, 16'h5678, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 2);
        add("sat pos",   16'h7F00, 16'h0000, 16'h0001, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 42);
        add("sat neg",   16'h8100, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b1, 42);
        add("-1/2",      16'hFF00, 16'h0000, 16'h0200, 16'h0000, 16'hFF80, 16'h0000, 1'b0, 1'b0, 42);
        add("1/3",       16'h0100, 16'h0000, 16'h0300, 16'h0000, 16'h0055, 16'h0000, 1'b0, 1'b0, 42);
        add("-1/3",      16'hFF00, 16'h0000, 16'h0300, 16'h0000, 16'hFFAB, 16'h0000, 1'b0, 1'b0, 42);
        add("min exact", 16'h8000, 16'h0000, 16'h0100, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0, 42);
        add("max mag",   16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0100, 16'h0000, 1'b0, 1'b0, 42);
        add("im sat",    16'h7F00, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b1, 42);
        add("(3+2i)/(1+2i)", 16'h0300, 16'h0200, 16'h0100, 16'h0200, 16'h0166, 16'hFF34, 1'b0, 1'b0, 42);

        foreach (vecs[i]) begin
            send(vecs[i]);
            drain();
        end

        // Stall in DONE while offering a new operand set that must be ignored.
        out_ready = 1'b0;
        v = vecs[0];
        v.name = "stall";
        send(v);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("stall result arrives", 64'(out_valid), 64'd1);
        num_re   = 16'h1111;
        num_im   = 16'h2222;
        den_re   = 16'h0100;
        den_im   = 16'h0000;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("stall released in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a division: result must never appear.
        v = vecs[0];
        v.name = "reset";
        send(v);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid reset out_valid", 64'(out_valid), 64'd0);
        check("mid reset in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no result after reset", 64'(seen), 64'd0);

        v = vecs[12];
        v.name = "after reset";
        send(v);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
